// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared constants and helpers for the FIFO read-stream drain stage.
//   BUF_DEPTH   : entries in the output buffer
//   BUF_CNT_W   : width of the buffer occupancy count
//   pkt_wrap()  : next beat index inside a packet of a given length
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  // Advance a beat index, wrapping to 0 after the last beat of the packet.
  function automatic logic [31:0] pkt_wrap(input logic [31:0] cnt,
                                           input logic [31:0] len);
    return (cnt == len - 32'd1) ? 32'd0 : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// -----------------------------------------------------------------------------
// skid_buf2
// Two-entry in-order register buffer. The head entry is always entry 0, so the
// consumer sees a registered value with no read mux.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : retire the head this cycle (only legal while cnt > 0)
//   head       : current head entry (registered)
//   cnt        : occupancy, 0..BUF_DEPTH
// -----------------------------------------------------------------------------
module skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter type T = logic
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  T                     push_data,
  input  logic                 pop,
  output T                     head,
  output logic [BUF_CNT_W-1:0] cnt
);

  localparam logic [BUF_CNT_W-1:0] FULL = BUF_CNT_W'(BUF_DEPTH);

  T e0;
  T e1;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      // NOTE: the data entries are reset as well because the head drives
      // out_data directly and must read 0 after reset; with only two entries
      // the reset cost is negligible.
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          // An empty buffer takes the word straight into the head slot.
          if (cnt == '0) e0 <= push_data;
          else           e1 <= push_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 1'b1;
        end
        2'b11: begin
          // Head advances to the entry behind it; the new word becomes the tail.
          if (cnt == FULL) begin
            e0 <= e1;
            e1 <= push_data;
          end else begin
            e0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drain stage for fifo_single_clock_reg_v1. Issues read requests, absorbs the
// FIFO read latency and presents the words as a valid/ready stream at one beat
// per cycle, with out_last marking every PKT_LEN-th beat.
//
// Build option: define FIFO_RD_STREAM_FWFT_EN when the upstream FIFO runs in
// first-word-fall-through mode (ff_r_req acts as an acknowledge and the word
// is captured in the same cycle). Undefined: normal mode, 1-cycle read latency.
//
// Ports:
//   clk        : clock
//   rst        : synchronous reset, active-high
//   ena        : read enable; buffered data still drains while low
//   ff_empty   : FIFO empty flag
//   ff_r_req   : FIFO read request (combinational, depends on out_ready)
//   ff_r_data  : FIFO read data
//   out_valid  : stream beat valid
//   out_ready  : stream consumer ready
//   out_data   : stream data (buffer head)
//   out_last   : last beat of packet, travels with out_data
//   buf_cnt    : output buffer occupancy, 0..2
//   beat_cnt   : beats transferred in the current packet, 0..PKT_LEN-1
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int PKT_LEN = 4,
  localparam int CNT_W   = $clog2(PKT_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              ff_empty,
  output logic              ff_r_req,
  input  logic [DATA_W-1:0] ff_r_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        buf_cnt,
  output logic [CNT_W-1:0]  beat_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic             pop;
  logic             push;
  logic             inflight;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] wr_cnt;
  entry_t           push_entry;
  entry_t           head;

  assign pop = out_valid & out_ready;

  // Credit check: words held plus words on their way, less the one leaving
  // this cycle, must leave room for one more.
  assign occupancy = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
  assign ff_r_req  = ~rst & ena & ~ff_empty & (occupancy < 3'(BUF_DEPTH));

`ifdef FIFO_RD_STREAM_FWFT_EN
  // Data is already presented; the request is the acknowledge.
  assign inflight = 1'b0;
  assign push     = ff_r_req;
`else
  // Normal mode: the word requested this cycle arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= ff_r_req;
  end
  assign push = inflight;
`endif

  // The last flag is decided when the word enters the buffer, so it is stored
  // beside the data. Since the buffer is in order, wr_cnt at push time equals
  // beat_cnt when that entry reaches the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) wr_cnt   <= CNT_W'(pkt_wrap(32'(wr_cnt),   32'(PKT_LEN)));
      if (pop)  beat_cnt <= CNT_W'(pkt_wrap(32'(beat_cnt), 32'(PKT_LEN)));
    end
  end

  assign push_entry = '{data: ff_r_data, last: (wr_cnt == LAST_IDX)};

  skid_buf2 #(
    .T (entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .cnt       (buf_cnt)
  );

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = head.data;
  assign out_last  = head.last;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Self-checking bench for fifo_rd_stream. A FIFO model (array + pointers)
// feeds the DUT in normal or FWFT mode to match the build; a queue of written
// words plus a beat index form the expected stream.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DATA_W  = 16;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = $clog2(PKT_LEN + 1);
`ifdef FIFO_RD_STREAM_FWFT_EN
  localparam bit FWFT = 1'b1;
  localparam int LAT  = 1;
`else
  localparam bit FWFT = 1'b0;
  localparam int LAT  = 2;
`endif
  localparam int N_RAND = 10000;

  logic              clk;
  logic              rst;
  logic              ena;
  logic              ff_empty;
  logic              ff_r_req;
  logic [DATA_W-1:0] ff_r_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        buf_cnt;
  logic [CNT_W-1:0]  beat_cnt;

  fifo_rd_stream #(
    .DATA_W  (DATA_W),
    .PKT_LEN (PKT_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .ff_empty  (ff_empty),
    .ff_r_req  (ff_r_req),
    .ff_r_data (ff_r_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .buf_cnt   (buf_cnt),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model and expected stream
  logic [DATA_W-1:0] mem [0:1023];
  int rd_ptr, wr_ptr;
  int exp_q[$];
  int beat_idx;

  // Statistics
  int n_assert, n_fail;
  int cyc, n_req, n_beat;
  int first_req, first_valid, last_pop_cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic refresh();
    ff_empty = (rd_ptr == wr_ptr);
    if (FWFT) ff_r_data = mem[rd_ptr % 1024];
  endtask

  task automatic fifo_write(input logic [DATA_W-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
    exp_q.push_back(int'(w));
    refresh();
  endtask

  task automatic model_reset();
    rd_ptr = 0;
    wr_ptr = 0;
    exp_q.delete();
    beat_idx = 0;
    refresh();
  endtask

  task automatic clear_stats();
    n_req = 0;
    n_beat = 0;
    first_req = -1;
    first_valid = -1;
    last_pop_cyc = -1;
  endtask

  // One clock cycle: observe mid-cycle, then advance the FIFO model after the edge.
  task automatic tick();
    logic req;
    logic pop;
    int   exp_w;
    #1;
    req = ff_r_req;
    pop = out_valid & out_ready;
    if (ff_empty) check("req_while_empty", 32'(ff_r_req), 32'd0);
    if (!rst) begin
      if (req) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (pop) begin
        n_beat++;
        last_pop_cyc = cyc;
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_beat: observed data %0h with no word pending", out_data);
        end
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(exp_w));
          check("beat_last", 32'(out_last), 32'(beat_idx == PKT_LEN - 1));
          beat_idx = (beat_idx + 1) % PKT_LEN;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (req) begin
      if (!FWFT) ff_r_data = mem[rd_ptr % 1024];
      rd_ptr++;
    end
    refresh();
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    ff_r_data = '0;
    clear_stats();

    // ---- Reset: outputs cleared and no request despite a non-empty FIFO ----
    rst = 1'b1;
    ena = 1'b1;
    out_ready = 1'b0;
    model_reset();
    fifo_write(16'hdead);
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_buf_cnt",   32'(buf_cnt),   32'd0);
    check("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    check("rst_req",       32'(ff_r_req),  32'd0);
    model_reset();
    rst = 1'b0;

    // ---- Continuous transfer of 8 preloaded words ----
    clear_stats();
    for (int i = 1; i <= 8; i++) fifo_write(DATA_W'(i));
    out_ready = 1'b1;
    repeat (30) tick();
    check("cont_latency", 32'(first_valid - first_req), 32'(LAT));
    check("cont_beats",   32'(n_beat), 32'd8);
    check("cont_reqs",    32'(n_req),  32'd8);
    check("cont_back2back", 32'(last_pop_cyc - first_valid), 32'd7);
    check("cont_drained", 32'(exp_q.size()), 32'd0);

    // ---- Back-pressure: 10 stalled cycles with 5 words waiting ----
    clear_stats();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_write(DATA_W'(16'h0001 + i));
    repeat (10) tick();
    check("bp_buf_cnt",   32'(buf_cnt),   32'd2);
    check("bp_req",       32'(ff_r_req),  32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data",  32'(out_data),  32'h0001);
    check("bp_reqs",      32'(n_req),     32'd2);
    out_ready = 1'b1;
    repeat (15) tick();
    check("bp_beats",   32'(n_beat), 32'd5);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // ---- Empty handling: 3 words, gap, then one more ----
    clear_stats();
    for (int i = 0; i < 3; i++) fifo_write(DATA_W'(16'h0100 + i));
    repeat (20) tick();
    fifo_write(16'h0200);
    repeat (20) tick();
    check("empty_beats", 32'(n_beat), 32'd4);
    check("empty_reqs",  32'(n_req),  32'd4);

    // ---- ena gating: drop ena right after the first request ----
    clear_stats();
    for (int i = 0; i < 4; i++) fifo_write(DATA_W'(16'h0300 + i));
    tick();
    check("ena_first_req", 32'(n_req), 32'd1);
    ena = 1'b0;
    repeat (15) tick();
    check("ena_off_beats",   32'(n_beat),  32'd1);
    check("ena_off_reqs",    32'(n_req),   32'd1);
    check("ena_off_buf_cnt", 32'(buf_cnt), 32'd0);
    ena = 1'b1;
    repeat (20) tick();
    check("ena_on_beats", 32'(n_beat), 32'd4);

    // ---- Mid-packet reset ----
    rst = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) fifo_write(DATA_W'(16'h0400 + i));
    for (int i = 0; i < 40 && n_beat < 2; i++) tick();
    check("mrst_pre_beats",    32'(n_beat),   32'd2);
    check("mrst_pre_beat_cnt", 32'(beat_cnt), 32'd2);
    rst = 1'b1;
    tick();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_buf_cnt",   32'(buf_cnt),   32'd0);
    check("mrst_beat_cnt",  32'(beat_cnt),  32'd0);
    model_reset();
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 4; i++) fifo_write(DATA_W'(16'h0500 + i));
    repeat (20) tick();
    check("mrst_post_beats", 32'(n_beat), 32'd4);
    check("mrst_post_beat_cnt", 32'(beat_cnt), 32'd0);

    // ---- Latency from ff_empty falling to out_valid ----
    clear_stats();
    fifo_write(16'h0600);
    repeat (5) tick();
    check("lat_empty_fall", 32'(first_valid - first_req), 32'(LAT));
    check("lat_beats", 32'(n_beat), 32'd1);

    // ---- Random traffic with random ready and enable ----
    begin
      int pushed;
      pushed = 0;
      clear_stats();
      for (int c = 0; c < 60000 && n_beat < N_RAND; c++) begin
        if (pushed < N_RAND && (wr_ptr - rd_ptr) < 16 && $urandom_range(0, 3) != 0) begin
          fifo_write(DATA_W'($urandom));
          pushed++;
        end
        out_ready = 1'(($urandom_range(0, 1)));
        ena = ($urandom_range(0, 15) != 0);
        tick();
      end
      check("rand_beats",   32'(n_beat), 32'(N_RAND));
      check("rand_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
